particle_writer: RTL and testbench

- Write-back end of the particle memory path.
- Accepts updated particles from the updater through a valid/ready handshake and buffers them in a small FIFO.
- Commits each buffered particle to particle BRAM at its index, one write per memory grant.
- Pulses write_finished per commit and frame_done once every PARTICLE_COUNT commits, so the fetch side can advance to the next particle or frame.

---
 rtl/particle_mem_pkg.sv | 22 ++
 rtl/particle_write_fifo.sv | 57 +++++
 rtl/particle_writer.sv | 178 +++++++++++++++++
 tb/tb_particle_writer.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/particle_mem_pkg.sv
// Shared types and helpers for the particle memory write path.
package particle_mem_pkg;

  // Default packed particle width; modules carry their own DATA_WIDTH parameter.
  localparam int PARTICLE_DEFAULT_WIDTH = 16;

  typedef logic [PARTICLE_DEFAULT_WIDTH-1:0] particle_t;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    WRITE       = 3'd1,
    VERIFY_RD   = 3'd2,
    VERIFY_WAIT = 3'd3,
    VERIFY_CMP  = 3'd4
  } writer_state_t;

  // BRAM read latency in cycles for a given RAM_PERFORMANCE mode.
  function automatic int read_latency(input string mode);
    return (mode == "LOW_LATENCY") ? 1 : 2;
  endfunction

endpackage

// File: rtl/particle_write_fifo.sv
// Synchronous write buffer for particle_writer. Head entry is visible
// combinationally; pushes when full and pops when empty are ignored.
// A pop does not free a slot for a push in the same cycle, because full
// is taken from the registered count.
module particle_write_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  import particle_mem_pkg::*;

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] store [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full      = (count == (PW+1)'(DEPTH));
  assign empty     = (count == '0);
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign head_data = store[rd_ptr];

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) store[wr_ptr] <= push_data;
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/particle_writer.sv
// Write-back end of the particle memory path: buffers updated particles and
// commits one per memory grant. Optional read-back verification is enabled
// by defining PARTICLE_WRITER_VERIFY_EN (adds mem_in / verify_error).
module particle_writer #(
  parameter int    ADDR_WIDTH            = 2,
  parameter int    DATA_WIDTH            = 16,
  parameter int    PARTICLE_COUNTER_SIZE = 2,
  parameter int    PARTICLE_COUNT        = 4,
  parameter int    FIFO_DEPTH            = 4,
  parameter string RAM_PERFORMANCE       = "HIGH_PERFORMANCE"
) (
  input  logic                             clk_in,
  input  logic                             rst,
  input  logic                             update_valid,
  input  logic [DATA_WIDTH-1:0]            update_data,
  input  logic [PARTICLE_COUNTER_SIZE-1:0] update_idx,
  output logic                             update_ready,
  input  logic                             mem_grant,
  output logic [ADDR_WIDTH-1:0]            addr_out,
  output logic [DATA_WIDTH-1:0]            mem_out,
  output logic                             mem_enable,
  output logic                             mem_write_enable,
  output logic                             write_finished,
  output logic                             frame_done,
  output logic [$clog2(FIFO_DEPTH):0]      pending
`ifdef PARTICLE_WRITER_VERIFY_EN
  ,
  input  logic [DATA_WIDTH-1:0]            mem_in,
  output logic                             verify_error
`endif
);
  import particle_mem_pkg::*;

  localparam int EW       = PARTICLE_COUNTER_SIZE + DATA_WIDTH;
  localparam int FW       = $clog2(PARTICLE_COUNT + 1);
  localparam int READ_LAT = read_latency(RAM_PERFORMANCE);
  localparam logic [FW-1:0] FRAME_LAST = FW'(PARTICLE_COUNT - 1);

  // Parameter sanity checks at elaboration.
  if (PARTICLE_COUNT < 1 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0
      || READ_LAT < 1) begin : g_bad_params
    $error("particle_writer: invalid parameter set");
  end

  writer_state_t                    state;
  logic [FW-1:0]                    frame_cnt;
  logic [EW-1:0]                    head;
  logic [PARTICLE_COUNTER_SIZE-1:0] head_idx;
  logic [DATA_WIDTH-1:0]            head_payload;
  logic [ADDR_WIDTH-1:0]            head_addr;
  logic                             fifo_full;
  logic                             fifo_empty;
  logic                             pop;
  logic                             frame_last;

  particle_write_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk_in),
    .rst       (rst),
    .push      (update_valid),
    .push_data ({update_idx, update_data}),
    .pop       (pop),
    .head_data (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (pending)
  );

  assign update_ready = !fifo_full;
  assign {head_idx, head_payload} = head;
  assign pop        = (state == IDLE) && !fifo_empty && mem_grant;
  assign frame_last = (frame_cnt == FRAME_LAST);

  // Index to address: zero-extend a narrow index, drop high bits of a wide one.
  if (PARTICLE_COUNTER_SIZE >= ADDR_WIDTH) begin : g_addr_trunc
    assign head_addr = head_idx[ADDR_WIDTH-1:0];
  end else begin : g_addr_ext
    assign head_addr = {{(ADDR_WIDTH-PARTICLE_COUNTER_SIZE){1'b0}}, head_idx};
  end

`ifdef PARTICLE_WRITER_VERIFY_EN
  logic [1:0] wait_cnt;

  // Commit FSM with read-back verify; the port is held from grant through VERIFY_CMP.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      frame_cnt        <= '0;
      addr_out         <= '0;
      mem_out          <= '0;
      mem_enable       <= 1'b0;
      mem_write_enable <= 1'b0;
      write_finished   <= 1'b0;
      frame_done       <= 1'b0;
      verify_error     <= 1'b0;
      wait_cnt         <= '0;
    end else begin
      write_finished <= 1'b0;
      frame_done     <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            addr_out         <= head_addr;
            mem_out          <= head_payload;
            mem_enable       <= 1'b1;
            mem_write_enable <= 1'b1;
            state            <= WRITE;
          end
        end
        WRITE: begin
          mem_write_enable <= 1'b0;
          state            <= VERIFY_RD;
        end
        VERIFY_RD: begin
          wait_cnt <= 2'(READ_LAT - 1);
          state    <= VERIFY_WAIT;
        end
        VERIFY_WAIT: begin
          if (wait_cnt == '0) begin
            write_finished <= 1'b1;
            frame_done     <= frame_last;
            frame_cnt      <= frame_last ? '0 : frame_cnt + 1'b1;
            state          <= VERIFY_CMP;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        VERIFY_CMP: begin
          if (mem_in != mem_out) verify_error <= 1'b1;
          mem_enable <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  // Commit FSM: one write strobe per grant, strobe cycle followed by a recovery cycle.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      frame_cnt        <= '0;
      addr_out         <= '0;
      mem_out          <= '0;
      mem_enable       <= 1'b0;
      mem_write_enable <= 1'b0;
      write_finished   <= 1'b0;
      frame_done       <= 1'b0;
    end else begin
      write_finished <= 1'b0;
      frame_done     <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            addr_out         <= head_addr;
            mem_out          <= head_payload;
            mem_enable       <= 1'b1;
            mem_write_enable <= 1'b1;
            write_finished   <= 1'b1;
            frame_done       <= frame_last;
            frame_cnt        <= frame_last ? '0 : frame_cnt + 1'b1;
            state            <= WRITE;
          end
        end
        WRITE: begin
          mem_enable       <= 1'b0;
          mem_write_enable <= 1'b0;
          state            <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_particle_writer.sv
// Self-checking bench for particle_writer (default build).
module tb_particle_writer;

  logic        clk_in = 1'b0;
  logic        rst = 1'b1;
  logic        update_valid = 1'b0;
  logic [15:0] update_data = '0;
  logic [1:0]  update_idx = '0;
  logic        update_ready;
  logic        mem_grant = 1'b0;
  logic [1:0]  addr_out;
  logic [15:0] mem_out;
  logic        mem_enable;
  logic        mem_write_enable;
  logic        write_finished;
  logic        frame_done;
  logic [2:0]  pending;
`ifdef PARTICLE_WRITER_VERIFY_EN
  logic [15:0] mem_in;
  logic        verify_error;
  logic [15:0] bram [4];
  always @(posedge clk_in) begin
    if (mem_enable && mem_write_enable) bram[addr_out] <= mem_out;
    mem_in <= bram[addr_out];
  end
`endif

  particle_writer dut (
    .clk_in           (clk_in),
    .rst              (rst),
    .update_valid     (update_valid),
    .update_data      (update_data),
    .update_idx       (update_idx),
    .update_ready     (update_ready),
    .mem_grant        (mem_grant),
    .addr_out         (addr_out),
    .mem_out          (mem_out),
    .mem_enable       (mem_enable),
    .mem_write_enable (mem_write_enable),
    .write_finished   (write_finished),
    .frame_done       (frame_done),
    .pending          (pending)
`ifdef PARTICLE_WRITER_VERIFY_EN
    ,
    .mem_in           (mem_in),
    .verify_error     (verify_error)
`endif
  );

  always #5 clk_in = ~clk_in;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: FIFO contents as a queue, commits counted per frame.
  typedef struct {
    logic [1:0]  idx;
    logic [15:0] data;
  } ent_t;

  ent_t q[$];
  ent_t pend_push;
  ent_t head_exp;
  bit   push_at_edge = 0;
  bit   grant_at_edge = 0;
  int   committed = 0;
  int   cycle = 0;
  int   last_commit = -1;

  always @(negedge clk_in) begin
    if (!rst) begin
      cycle++;
      if (write_finished) begin
        check("commit_grant", 32'(grant_at_edge), 32'd1);
        if (q.size() == 0) begin
          check("spurious_commit", 32'(q.size()), 32'd1);
        end else begin
          head_exp = q.pop_front();
          committed++;
          check("commit_addr", 32'(addr_out), 32'(head_exp.idx));
          check("commit_data", 32'(mem_out), 32'(head_exp.data));
          check("frame_done", 32'(frame_done), 32'((committed % 4) == 0));
        end
        if (last_commit >= 0) check("commit_gap_ge2", 32'((cycle - last_commit) >= 2), 32'd1);
        last_commit = cycle;
      end else begin
        check("frame_done_quiet", 32'(frame_done), 32'd0);
      end
      if (push_at_edge) q.push_back(pend_push);
      check("pending", 32'(pending), 32'(q.size()));
      check("ready", 32'(update_ready), 32'(q.size() < 4));
      push_at_edge  = update_valid && (q.size() < 4);
      pend_push     = '{update_idx, update_data};
      grant_at_edge = mem_grant;
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    #2;
    rst = 1'b1;
    update_valid = 1'b0;
    #1;
    check("rst_wf", 32'(write_finished), 32'd0);
    check("rst_fd", 32'(frame_done), 32'd0);
    check("rst_en", 32'(mem_enable), 32'd0);
    check("rst_we", 32'(mem_write_enable), 32'd0);
    check("rst_addr", 32'(addr_out), 32'd0);
    check("rst_data", 32'(mem_out), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    q.delete();
    committed     = 0;
    push_at_edge  = 0;
    grant_at_edge = 0;
    last_commit   = -1;
    repeat (2) @(posedge clk_in);
    #1;
    rst = 1'b0;
  endtask

  // Wait (bounded) for n commits; returns count seen.
  task automatic wait_commits(input int n, input int budget, output int seen, output int fd_seen);
    seen = 0;
    fd_seen = 0;
    for (int i = 0; i < budget && seen < n; i++) begin
      tick();
      if (write_finished) seen++;
      if (frame_done) fd_seen++;
    end
  endtask

  int seen, fd_seen, first_wf, prev_wf, wf_cnt;

  initial begin
    do_reset();

    // Single push, latency and strobe width.
    mem_grant = 1'b1;
    update_idx = 2'd2;
    update_data = 16'hABCD;
    update_valid = 1'b1;
    tick();
    update_valid = 1'b0;
    check("lat_edgeN_wf", 32'(write_finished), 32'd0);
    check("lat_edgeN_pending", 32'(pending), 32'd1);
    tick();
    check("lat_wf", 32'(write_finished), 32'd1);
    check("lat_en", 32'(mem_enable), 32'd1);
    check("lat_we", 32'(mem_write_enable), 32'd1);
    check("lat_addr", 32'(addr_out), 32'd2);
    check("lat_data", 32'(mem_out), 32'hABCD);
    check("lat_pending", 32'(pending), 32'd0);
    tick();
    check("strobe_end_wf", 32'(write_finished), 32'd0);
    check("strobe_end_we", 32'(mem_write_enable), 32'd0);
    check("hold_addr", 32'(addr_out), 32'd2);
    check("hold_data", 32'(mem_out), 32'hABCD);

    // Grant low: fill to full, fifth push refused, then drain spaced by 2.
    mem_grant = 1'b0;
    update_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      update_idx  = 2'(i);
      update_data = 16'(16'h1000 + i);
      tick();
      check("fill_ready", 32'(update_ready), 32'(i < 3));
      check("fill_no_strobe", 32'(write_finished), 32'd0);
    end
    update_valid = 1'b0;
    check("fill_pending", 32'(pending), 32'd4);
    tick();
    check("grant_low_hold", 32'(write_finished), 32'd0);
    mem_grant = 1'b1;
    first_wf = -1;
    prev_wf = -1;
    wf_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (write_finished) begin
        if (prev_wf >= 0) check("drain_spacing", 32'(i - prev_wf), 32'd2);
        prev_wf = i;
        wf_cnt++;
      end
    end
    check("drain_count", 32'(wf_cnt), 32'd4);

    // Frame boundaries over 8 commits after a clean reset.
    do_reset();
    mem_grant = 1'b1;
    for (int i = 0; i < 8; i++) begin
      update_valid = 1'b1;
      update_idx   = 2'($urandom);
      update_data  = 16'($urandom);
      tick();
      update_valid = 1'b0;
      tick();
    end
    wait_commits(1, 20, seen, fd_seen);
    repeat (4) tick();
    check("frame_commits", 32'(committed), 32'd8);

    // Reset in the WRITE cycle with 3 still pending.
    mem_grant = 1'b0;
    update_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      update_idx  = 2'(3 - i);
      update_data = 16'(16'h2200 + i);
      tick();
    end
    update_valid = 1'b0;
    mem_grant = 1'b1;
    tick();
    check("midwrite_wf", 32'(write_finished), 32'd1);
    check("midwrite_pending", 32'(pending), 32'd3);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      update_valid = 1'b1;
      update_idx   = 2'(i);
      update_data  = 16'(16'h3300 + i);
      tick();
      update_valid = 1'b0;
      tick();
    end
    repeat (4) tick();
    check("post_rst_commits", 32'(committed), 32'd4);

    // Two queued, then push every cycle with grant high.
    mem_grant = 1'b0;
    update_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      update_data = 16'($urandom);
      update_idx  = 2'($urandom);
      tick();
    end
    mem_grant = 1'b1;
    for (int i = 0; i < 8; i++) begin
      update_data = 16'($urandom);
      update_idx  = 2'($urandom);
      tick();
    end
    update_valid = 1'b0;
    repeat (16) tick();
    check("stream_drained", 32'(pending), 32'd0);

    // Randomized traffic with random grant gaps.
    for (int i = 0; i < 400; i++) begin
      update_valid = 1'($urandom_range(0, 1));
      update_data  = 16'($urandom);
      update_idx   = 2'($urandom);
      mem_grant    = ($urandom_range(0, 3) != 0);
      tick();
    end
    update_valid = 1'b0;
    mem_grant = 1'b1;
    repeat (20) tick();
    check("rand_drained", 32'(pending), 32'd0);
    check("rand_model_empty", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
